// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
`timescale 1ns/1ps
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PROC = 2'b01,
    HOST = 2'b10
  } arb_state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_HOST = 2'b10;

  localparam int CNT_W = 16;

  // Reserved status 2'b11 falls back to IDLE.
  function automatic arb_state_t decode_status(input logic [1:0] status);
    arb_state_t st;
    case (status)
      ST_PROC: st = PROC;
      ST_HOST: st = HOST;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer; the pointer only
// moves past the winner, so an idle cycle leaves fairness untouched.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          hit;
  int            idx;

  // Scan from the pointer, wrapping modulo N, and take the first requester.
  always_comb begin
    gnt      = {N{1'b0}};
    ptr_next = ptr_r;
    found    = 1'b0;
    hit      = 1'b0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      idx      = int'(ptr_r) + off;
      idx      = (idx >= N) ? (idx - N) : idx;
      hit      = enable && !found && req[idx];
      gnt[idx] = gnt[idx] | hit;
      ptr_next = hit ? ((idx == N - 1) ? {PW{1'b0}} : PW'(idx + 1)) : ptr_next;
      found    = found | hit;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= {PW{1'b0}};
    end else begin
      ptr_r <= ptr_next;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates NUM_CORES core ports and one host port onto one synchronous
// data-memory port. Optional per-core grant counters: DMEM_ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  status,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic                        host_rvalid,
  output logic [NUM_CORES*16-1:0]     perf_gnt_cnt
);

  localparam int ID_W = $clog2(NUM_CORES);

  arb_state_t        state_r;
  logic              proc_en;
  logic              sel_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ID_W-1:0]   sel_id;

  // Read-return tag pipeline: stage 1 aligns with mem_*, stage 2 with mem_rdata.
  logic              tag1_v, tag2_v;
  logic              tag1_host, tag2_host;
  logic [ID_W-1:0]   tag1_id, tag2_id;

  // Mode register; grants follow it, so status changes act one cycle late.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= decode_status(status);
    end
  end

  assign proc_en  = (state_r == PROC);
  assign host_gnt = (state_r == HOST) && host_req;

  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (core_req),
    .enable  (proc_en),
    .gnt     (core_gnt)
  );

  // One-hot OR-mux of the granted requester's fields; host and cores never coexist.
  always_comb begin
    sel_valid = (|core_gnt) | host_gnt;
    sel_we    = 1'b0;
    sel_addr  = {ADDR_W{1'b0}};
    sel_wdata = {DATA_W{1'b0}};
    sel_id    = {ID_W{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_we    = sel_we | (core_gnt[i] & core_we[i]);
      sel_addr  = sel_addr  | ({ADDR_W{core_gnt[i]}} & core_addr[i*ADDR_W +: ADDR_W]);
      sel_wdata = sel_wdata | ({DATA_W{core_gnt[i]}} & core_wdata[i*DATA_W +: DATA_W]);
      sel_id    = sel_id    | (core_gnt[i] ? ID_W'(i) : {ID_W{1'b0}});
    end
    if (host_gnt) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end else begin
      sel_we    = sel_we;
    end
  end

  // Memory command register; address/data hold while idle, write enable drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (sel_valid) begin
      mem_en    <= 1'b1;
      mem_we    <= sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Tag shift pipeline; independent of state so issued reads always return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag1_v    <= 1'b0;
      tag1_host <= 1'b0;
      tag1_id   <= {ID_W{1'b0}};
      tag2_v    <= 1'b0;
      tag2_host <= 1'b0;
      tag2_id   <= {ID_W{1'b0}};
    end else begin
      tag1_v    <= sel_valid & ~sel_we;
      tag1_host <= host_gnt;
      tag1_id   <= sel_id;
      tag2_v    <= tag1_v;
      tag2_host <= tag1_host;
      tag2_id   <= tag1_id;
    end
  end

  // Read-return register with one-cycle valid pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data     <= {DATA_W{1'b0}};
      core_rvalid <= {NUM_CORES{1'b0}};
      host_rvalid <= 1'b0;
    end else begin
      rd_data     <= tag2_v ? mem_rdata : rd_data;
      core_rvalid <= (tag2_v && !tag2_host) ?
                     ({{(NUM_CORES-1){1'b0}}, 1'b1} << tag2_id) : {NUM_CORES{1'b0}};
      host_rvalid <= tag2_v & tag2_host;
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_r [NUM_CORES];
  logic             perf_clear;

  assign perf_clear = (state_r == IDLE) && (decode_status(status) == PROC);

  // Saturating per-core grant counters, cleared when processing (re)starts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (perf_clear) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (core_gnt[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_perf
    assign perf_gnt_cnt[g*16 +: 16] = cnt_r[g];
  end
`else
  assign perf_gnt_cnt = {(NUM_CORES*16){1'b0}};
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a cycle model predicts grants and
// memory commands; expected read returns are queued at grant and popped when due.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      status;
  logic [NC-1:0]   core_req, core_we;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]   core_gnt;
  logic            host_req, host_we;
  logic [AW-1:0]   host_addr;
  logic [DW-1:0]   host_wdata;
  logic            host_gnt;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   rd_data;
  logic [NC-1:0]   core_rvalid;
  logic            host_rvalid;
  logic [NC*16-1:0] perf_gnt_cnt;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .status(status),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .core_rvalid(core_rvalid),
    .host_rvalid(host_rvalid), .perf_gnt_cnt(perf_gnt_cnt)
  );

  // Synchronous memory model, low 8 address bits.
  logic [DW-1:0] mem_arr [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  typedef struct {
    int          due;
    bit          host;
    int          id;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [15:0] shadow [256];
  logic [15:0] m_cnt [NC];
  int          m_state, m_ptr, cyc;
  int          checks, errors;
  logic        prev_en, prev_we;
  logic [15:0] prev_addr, prev_wdata;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; prev_en = 1'b0; prev_we = 1'b0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 16'h0000;
    sb.delete();
  endtask

  task automatic check_perf();
    logic [NC*16-1:0] e;
    e = '0;
`ifdef DMEM_ARB_PERF_CNT_EN
    for (int i = 0; i < NC; i++) e[i*16 +: 16] = m_cnt[i];
`endif
    check_val("perf_cnt", perf_gnt_cnt, e);
  endtask

  // One clock cycle: drive, check against the model, update the model, advance.
  task automatic run_cycle(input logic [1:0] st, input logic [NC-1:0] rq, input logic [NC-1:0] we,
                           input logic hr, input logic hw);
    logic [NC-1:0] eg, ecv;
    logic          eh, ehv, found;
    int            gid, k;
    logic [15:0]   a, d;
    rd_exp_t       e;
    status = st; core_req = rq; core_we = we; host_req = hr; host_we = hw;
    #1;
    eg = '0; eh = 1'b0; found = 1'b0; gid = 0;
    if (m_state == 1) begin
      for (int off = 0; off < NC; off++) begin
        k = (m_ptr + off) % NC;
        if (rq[k] && !found) begin eg[k] = 1'b1; gid = k; found = 1'b1; end
      end
    end else if (m_state == 2) begin
      eh = hr;
    end
    check_val("core_gnt", core_gnt, eg);
    check_val("host_gnt", host_gnt, eh);
    check_val("mem_en", mem_en, prev_en);
    if (prev_en) begin
      check_val("mem_we", mem_we, prev_we);
      check_val("mem_addr", mem_addr, prev_addr);
      if (prev_we) check_val("mem_wdata", mem_wdata, prev_wdata);
    end else begin
      check_val("mem_we_idle", mem_we, 1'b0);
    end
    ecv = '0; ehv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.host) ehv = 1'b1; else ecv[e.id] = 1'b1;
      check_val("rd_data", rd_data, e.data);
    end
    check_val("core_rvalid", core_rvalid, ecv);
    check_val("host_rvalid", host_rvalid, ehv);
    check_perf();
    // model update
    prev_en = found | eh;
    if (found) begin
      a = core_addr[gid*16 +: 16]; d = core_wdata[gid*16 +: 16]; prev_we = we[gid];
    end else begin
      a = host_addr; d = host_wdata; prev_we = eh & hw;
    end
    if (prev_en) begin
      prev_addr = a; prev_wdata = d;
      if (prev_we) shadow[a[7:0]] = d;
      else sb.push_back('{due: cyc + 3, host: eh, id: gid, data: shadow[a[7:0]]});
    end else begin
      prev_we = 1'b0;
    end
    if (m_state == 0 && st == 2'b01) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = 16'h0000;
    end else if (found && m_cnt[gid] != 16'hFFFF) begin
      m_cnt[gid] = m_cnt[gid] + 16'h0001;
    end
    if (found) m_ptr = (gid + 1) % NC;
    @(posedge clock); #1;
    cyc++;
    m_state = (st == 2'b01) ? 1 : (st == 2'b10) ? 2 : 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_en"}, {mem_en, mem_we, host_gnt, host_rvalid}, 4'b0000);
    check_val({tag, "_addr"}, mem_addr, 16'h0000);
    check_val({tag, "_wdata"}, mem_wdata, 16'h0000);
    check_val({tag, "_rd"}, rd_data, 16'h0000);
    check_val({tag, "_gnt_rv"}, {core_gnt, core_rvalid}, 8'h00);
    check_val({tag, "_perf"}, perf_gnt_cnt, 64'h0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'(i * 3 + 16'h0101);
      shadow[i]  = 16'(i * 3 + 16'h0101);
    end
    mem_arr[8'h40] = 16'hBEEF; shadow[8'h40] = 16'hBEEF;
    mem_rdata = 16'h0000;
    reset_n = 1'b0; status = 2'b00; core_req = '0; core_we = '0;
    core_addr = '0; core_wdata = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Round robin: all cores request continuously
    for (int i = 0; i < NC; i++) core_addr[i*16 +: 16] = 16'h0020 + 16'(i);
    run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) run_cycle(2'b01, 4'hF, 4'h0, 1'b0, 1'b0);

    // Mixed random traffic kept away from the fixed test addresses
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NC; i++) begin
        core_addr[i*16 +: 16]  = 16'h0080 + 16'($urandom_range(0, 127));
        core_wdata[i*16 +: 16] = 16'($urandom);
      end
      run_cycle(2'b01, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    end
    repeat (4) run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);

    // Read latency: core 3 reads 0x0040
    core_addr[3*16 +: 16] = 16'h0040;
    run_cycle(2'b01, 4'b1000, 4'h0, 1'b0, 1'b0);
    repeat (2) run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("lat_rd_data", rd_data, 16'hBEEF);
    check_val("lat_rvalid", core_rvalid, 4'b1000);
    repeat (2) run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);

    // Mode switch: core 0 read in flight while moving to HOST
    core_addr[0 +: 16] = 16'h0011;
    host_addr = 16'h0005; host_wdata = 16'h1234;
    run_cycle(2'b10, 4'b0001, 4'h0, 1'b1, 1'b1);
    run_cycle(2'b10, 4'hF, 4'h0, 1'b1, 1'b1);
    run_cycle(2'b10, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (4) run_cycle(2'b10, 4'hF, 4'h0, 1'b0, 1'b0);

    // Reserved status behaves as idle
    repeat (4) run_cycle(2'b11, 4'hF, 4'hF, 1'b1, 1'b1);

    // Reset while a core 2 read is in flight
    core_addr[2*16 +: 16] = 16'h0010;
    run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    run_cycle(2'b01, 4'b0100, 4'h0, 1'b0, 1'b0);
    run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    status = 2'b01; core_req = '0;
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clock); #1;
    cyc++;
    check_all_zero("midrst_hold");
    reset_n = 1'b1;
    repeat (5) run_cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);

`ifdef DMEM_ARB_PERF_CNT_EN
    run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 70000; c++) run_cycle(2'b01, 4'b0001, 4'h0, 1'b0, 1'b0);
    check_val("perf_sat", perf_gnt_cnt[15:0], 16'hFFFF);
    repeat (3) run_cycle(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    run_cycle(2'b01, 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("perf_clear", perf_gnt_cnt[15:0], 16'h0000);
`endif

    check_val("sb_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Parametrised successor to the fixed four-core data-memory selector.
- Arbitrates NUM_CORES core data-memory ports and one host load/unload port onto a single synchronous data-memory port.
- Round-robin grant among cores while processing; exclusive host access while loading.
- Adds read-data return with per-requester valid, request/grant handshake and a mode state machine.

Parameters:
- NUM_CORES, 4, number of core request ports (2..16)
- DATA_W, 16, data word width
- ADDR_W, 16, data-memory address width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- status  in  2  mode: 00 idle, 01 processing, 10 host access, 11 treated as idle
- core_req  in  NUM_CORES  per-core access request
- core_we  in  NUM_CORES  per-core write enable (0 = read)
- core_addr  in  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data
- core_gnt  out  NUM_CORES  one-hot grant, combinational
- host_req, host_we  in  1 each  host access request / write enable
- host_addr  in  ADDR_W;  host_wdata  in  DATA_W
- host_gnt  out  1  host grant, combinational
- mem_en, mem_we  out  1 each  registered memory enable / write enable
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en
- rd_data  out  DATA_W  registered read-return data
- core_rvalid  out  NUM_CORES  one-hot read-return valid
- host_rvalid  out  1  host read-return valid
- perf_gnt_cnt  out  NUM_CORES*16  per-core grant counters (see optional feature)

Behaviour:
- Reset:
  - All registered outputs are 0, state is IDLE, round-robin pointer is 0.
  - The read pipeline is flushed; no rvalid fires after reset, even if a read was in flight.
- State register: IDLE, PROC, HOST. Loaded every cycle from status (01→PROC, 10→HOST, else IDLE). Grants use the registered state, so a status change takes effect one cycle later.
- Handshake:
  - A requester holds req and its fields stable until it sees gnt high in the same cycle.
  - The transfer completes at that rising edge; the requester may present its next request in the following cycle.
- PROC:
  - At most one core_gnt per cycle. Priority starts at pointer p and wraps modulo NUM_CORES.
  - After a grant to core i, p becomes (i+1) mod NUM_CORES; p is unchanged when there is no grant.
  - host_gnt is 0.
- HOST: host_gnt = host_req; core_gnt = 0.
- IDLE: no grants; mem_en = 0.
- Latency: grant in cycle t → mem_* driven in cycle t+1 → mem_rdata valid in cycle t+2 → rd_data and matching rvalid valid in cycle t+3, one-cycle pulse.
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined, one per cycle.
- The read-return tag (requester id plus host flag) travels in a 2-stage shift pipeline. Reads already issued complete and return even if state changes mid-flight.
- mem_we, mem_addr and mem_wdata hold their last value when mem_en = 0; mem_we is forced 0 when mem_en = 0.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined:
  - Per-core 16-bit counter increments on each core_gnt and saturates at 16'hFFFF.
  - Counters clear on reset and on each IDLE→PROC transition.
- Undefined: perf_gnt_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE, PROC, HOST)
  - status encodings (ST_IDLE=2'b00, ST_PROC=2'b01, ST_HOST=2'b10)
  - the counter width constant (16)
- One sub-module, rr_arbiter:
  - parametrised N
  - inputs req and enable
  - outputs one-hot gnt
  - owns the pointer register

Test Plan:
- Reset mid-read:
  - Stimulus: status=01, core 2 reads addr 0x0010, assert reset_n=0 in cycle t+2.
  - Response: all outputs 0, no core_rvalid afterwards.
- Round robin:
  - Stimulus: status=01, all four cores request continuously.
  - Response: grants 0,1,2,3,0,… one per cycle; core 1 sees mem_addr = its address one cycle after its grant.
- Read latency:
  - Stimulus: memory model holds 0xBEEF at 0x0040; core 3 reads 0x0040, granted in cycle t.
  - Response: core_rvalid=4'b1000 and rd_data=0xBEEF in cycle t+3 only.
- Mode switch:
  - Stimulus: core 0 read issued in cycle t; status→10 in cycle t; host writes 0x1234 to 0x0005.
  - Response: core 0 rvalid still arrives in cycle t+3; host_gnt=1 from cycle t+1; core_gnt=0 in HOST.
- Idle and reserved status:
  - Stimulus: status=11, all requests high.
  - Response: no grants, mem_en=0.
- Counter saturation (DMEM_ARB_PERF_CNT_EN defined):
  - Stimulus: core 0 sole requester for 70000 cycles.
  - Response: perf_gnt_cnt[15:0]=16'hFFFF, and it clears on the next IDLE→PROC transition.
